mem_read_streamer: RTL and testbench
====================================

// Module: mem_read_streamer
// PURPOSE
//   Read-side controller for a simple dual-port block RAM configured with a registered output
//   (2-cycle read latency: RD_ENB stage, then OUT_ENB stage).
//   Accepts a burst request (start address, length), drives the RAM read port and presents the
//   words as a valid/ready stream with full back-pressure and no data loss.
//   Sits between a cache/line buffer RAM and its consumer (refill/writeback path).
// PARAMETERS
//   RAM_WIDTH   64   data word width; must match the RAM instance
//   RAM_DEPTH   512  RAM entries; must match the RAM instance
//   ADDR_WIDTH  9    derived as ceil(log2(RAM_DEPTH)); not overridden independently
//   LEN_WIDTH   10   width of burst length field
// PORTS
//   CLK          in   1           clock, all logic on rising edge
//   RSTN         in   1           asynchronous active-low reset
//   REQ_VALID    in   1           burst request valid
//   REQ_READY    out  1           controller can accept a request (state IDLE and ABORT low)
//   REQ_ADDR     in   ADDR_WIDTH  first word address
//   REQ_LEN      in   LEN_WIDTH   word count (0 permitted)
//   ABORT        in   1           synchronous flush of the active burst
//   RAM_ADDR_R   out  ADDR_WIDTH  to RAM ADDR_R
//   RAM_RD_ENB   out  1           to RAM RD_ENB
//   RAM_OUT_ENB  out  1           to RAM OUT_ENB
//   RAM_OUT_RST  out  1           to RAM OUT_RST
//   RAM_DATA_OUT in   RAM_WIDTH   from RAM DATA_OUT
//   DATA_OUT     out  RAM_WIDTH   stream data (combinational from RAM_DATA_OUT)
//   DATA_VALID   out  1           stream valid
//   DATA_READY   in   1           stream ready
//   DATA_LAST    out  1           marks final word of the burst
//   DONE         out  1           1-cycle pulse after the last word is transferred
// BEHAVIOUR
//   Reset (RSTN=0): state IDLE; v1, v2, l1, l2, remaining count, address and DONE cleared.
//     Resulting outputs: DATA_VALID=0, DATA_LAST=0, DONE=0, RAM_RD_ENB=0, RAM_OUT_RST=0,
//     RAM_ADDR_R=0, REQ_READY=1.
//   States
//     IDLE  -> on REQ_VALID & REQ_READY: latch address and length.
//              LEN>0 goes to ISSUE. LEN=0 stays in IDLE and pulses DONE on the next cycle.
//     ISSUE -> issues one read on every advance cycle. After issuing word LEN-1, goes to DRAIN.
//     DRAIN -> when v1=0 and the last word handshakes: DONE pulse on the next cycle, then IDLE.
//   Pipeline tracking: v1/l1 = RAM internal stage valid/last; v2/l2 = RAM output register valid/last.
//   Control signals
//     advance     = !v2 | DATA_READY
//     RAM_OUT_ENB = advance
//     RAM_RD_ENB  = (state==ISSUE) & advance
//     On each advance: v2<=v1, l2<=l1, v1<=RAM_RD_ENB, l1<=RAM_RD_ENB & (remaining==1).
//     When advance=0 the whole RAM pipeline freezes, so data is held and never dropped.
//   Stream outputs: DATA_VALID=v2, DATA_LAST=l2, DATA_OUT=RAM_DATA_OUT.
//     DATA_OUT and DATA_LAST stay stable while DATA_VALID=1 and DATA_READY=0.
//   Latency: request accepted in cycle 0 -> RAM_RD_ENB high in cycle 1 -> DATA_VALID high in cycle 3.
//     Throughput is 1 word/cycle while DATA_READY=1.
//   Address: increments by 1 per issued read. Wraps from RAM_DEPTH-1 to 0, including non-power-of-2 depths.
//   ABORT (any state): state<=IDLE and v1,v2,l1,l2<=0 on the next edge; no DONE is generated.
//     RAM_OUT_RST=1 and RAM_RD_ENB=0 in the ABORT cycle. ABORT has priority over a simultaneous request.
//     REQ_READY=0 while ABORT=1.
//   Reset asserted mid-burst: behaves exactly as power-on reset; no DONE is generated.
// TESTING
//   1. ADDR=5, LEN=4, DATA_READY=1, RAM[5..8]=A,B,C,D -> DATA_VALID in cycles 3-6 carrying A..D;
//      DATA_LAST only on D; DONE in cycle 7.
//   2. ADDR=510, LEN=4, DEPTH=512 -> RAM_ADDR_R sequence 510,511,0,1; data order preserved.
//   3. LEN=8, DATA_READY toggled 1,0,0,1 repeating -> exactly 8 words, in order, none duplicated;
//      DATA_OUT stable while stalled.
//   4. LEN=0 -> no RAM_RD_ENB, no DATA_VALID; DONE pulses the cycle after acceptance.
//   5. ABORT at the 3rd word of a LEN=16 burst -> DATA_VALID=0 and REQ_READY=1 next cycle, no DONE;
//      a new LEN=2 burst then completes cleanly.
//   6. RSTN low mid-burst, then release -> all outputs at reset values; next request behaves as in test 1.

Source files
------------

// File: rtl/mem_read_streamer.sv
// Burst read controller for a 2-cycle registered-output block RAM.
// Ports: request (REQ_*), RAM read port (RAM_*), valid/ready stream (DATA_*), DONE, ABORT.
module mem_read_streamer #(
  parameter int RAM_WIDTH  = 64,
  parameter int RAM_DEPTH  = 512,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [LEN_WIDTH-1:0]  REQ_LEN,
  input  logic                  ABORT,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR_R,
  output logic                  RAM_RD_ENB,
  output logic                  RAM_OUT_ENB,
  output logic                  RAM_OUT_RST,
  input  logic [RAM_WIDTH-1:0]  RAM_DATA_OUT,
  output logic [RAM_WIDTH-1:0]  DATA_OUT,
  output logic                  DATA_VALID,
  input  logic                  DATA_READY,
  output logic                  DATA_LAST,
  output logic                  DONE
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [1:0]            state;
  logic                  v1, v2, l1, l2;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  done_q;
  logic                  advance;
  logic                  rd_enb;
  logic                  is_idle;
  logic                  is_issue;
  logic                  is_drain;
  logic                  last_rem;
  logic                  last_xfer;

  assign is_idle  = (state == IDLE);
  assign is_issue = (state == ISSUE);
  assign is_drain = (state == DRAIN);

  // The whole RAM pipeline moves only when the output slot can empty.
  assign advance   = !v2 | DATA_READY;
  assign rd_enb    = is_issue & advance & !ABORT;
  assign last_rem  = (remaining == LEN_WIDTH'(1));
  assign last_xfer = !v1 & v2 & l2 & DATA_READY;

  // Explicit wrap so non-power-of-2 depths work.
  assign addr_nxt = (addr == LAST_ADDR) ? '0 : addr + 1'b1;

  assign REQ_READY   = is_idle & !ABORT;
  assign RAM_ADDR_R  = addr;
  assign RAM_RD_ENB  = rd_enb;
  assign RAM_OUT_ENB = advance;
  assign RAM_OUT_RST = ABORT;
  assign DATA_OUT    = RAM_DATA_OUT;
  assign DATA_VALID  = v2;
  assign DATA_LAST   = l2;
  assign DONE        = done_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      v1        <= 1'b0;
      v2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      remaining <= '0;
      addr      <= '0;
      done_q    <= 1'b0;
    end else if (ABORT) begin
      state  <= IDLE;
      v1     <= 1'b0;
      v2     <= 1'b0;
      l1     <= 1'b0;
      l2     <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (advance) begin
        v2 <= v1;
        l2 <= l1;
        v1 <= rd_enb;
        l1 <= rd_enb & last_rem;
      end
      unique case (1'b1)
        is_idle: begin
          if (REQ_VALID) begin
            addr      <= REQ_ADDR;
            remaining <= REQ_LEN;
            if (REQ_LEN == '0) done_q <= 1'b1;
            else               state  <= ISSUE;
          end
        end
        is_issue: begin
          if (rd_enb) begin
            addr      <= addr_nxt;
            remaining <= remaining - 1'b1;
            if (last_rem) state <= DRAIN;
          end
        end
        is_drain: begin
          if (last_xfer) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Self-checking bench for mem_read_streamer with a behavioural RAM.
// Checks bursts from a vector table, random bursts, ABORT and mid-burst reset.
module tb_mem_read_streamer;

  localparam int W  = 64;
  localparam int D  = 512;
  localparam int AW = 9;
  localparam int LW = 10;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [LW-1:0] REQ_LEN = '0;
  logic          ABORT = 1'b0;
  logic [AW-1:0] RAM_ADDR_R;
  logic          RAM_RD_ENB;
  logic          RAM_OUT_ENB;
  logic          RAM_OUT_RST;
  logic [W-1:0]  RAM_DATA_OUT;
  logic [W-1:0]  DATA_OUT;
  logic          DATA_VALID;
  logic          DATA_READY = 1'b1;
  logic          DATA_LAST;
  logic          DONE;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [0:D-1];
  logic [W-1:0] ram_int;
  logic [W-1:0] ram_out;

  always #5 CLK = ~CLK;

  mem_read_streamer #(
    .RAM_WIDTH(W), .RAM_DEPTH(D),
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .ABORT(ABORT),
    .RAM_ADDR_R(RAM_ADDR_R), .RAM_RD_ENB(RAM_RD_ENB),
    .RAM_OUT_ENB(RAM_OUT_ENB), .RAM_OUT_RST(RAM_OUT_RST),
    .RAM_DATA_OUT(RAM_DATA_OUT),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .DATA_LAST(DATA_LAST),
    .DONE(DONE)
  );

  // Two-stage registered-output RAM read port.
  always @(posedge CLK) begin
    if (RAM_RD_ENB) ram_int <= mem[RAM_ADDR_R];
    if (RAM_OUT_RST)      ram_out <= '0;
    else if (RAM_OUT_ENB) ram_out <= ram_int;
  end
  assign RAM_DATA_OUT = ram_out;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, DATA_VALID, 0);
    chk({tag, "_last"}, DATA_LAST, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_rd_enb"}, RAM_RD_ENB, 0);
    chk({tag, "_out_rst"}, RAM_OUT_RST, 0);
    chk({tag, "_addr"}, RAM_ADDR_R, 0);
    chk({tag, "_req_ready"}, REQ_READY, 1);
  endtask

  // Issues one burst and checks it against the expected word sequence.
  // Entered and left at #1 after a rising edge.
  task automatic run_burst(input int addr, input int len, input int mode,
                           input int exp_first, input int exp_done);
    int issued = 0;
    int got = 0;
    int first = -1;
    int done_k = -1;
    bit stalled = 0;
    logic [W-1:0] hold_d = '0;
    logic hold_l = 0;
    REQ_ADDR = AW'(addr);
    REQ_LEN = LW'(len);
    REQ_VALID = 1'b1;
    DATA_READY = 1'b1;
    @(negedge CLK);
    chk("req_ready", REQ_READY, 1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    for (int k = 1; k < 200; k++) begin
      DATA_READY = rdy(mode, k);
      @(negedge CLK);
      if (stalled) begin
        chk("hold_valid", DATA_VALID, 1);
        chk("hold_data", DATA_OUT, hold_d);
        chk("hold_last", DATA_LAST, hold_l);
      end
      stalled = DATA_VALID && !DATA_READY;
      hold_d = DATA_OUT;
      hold_l = DATA_LAST;
      if (RAM_RD_ENB) begin
        chk("rd_addr", RAM_ADDR_R, (addr + issued) % D);
        issued++;
      end
      if (DATA_VALID && first < 0) first = k;
      if (DATA_VALID && DATA_READY) begin
        if (got < len) begin
          chk("data", DATA_OUT, mem[(addr + got) % D]);
          chk("last", DATA_LAST, got == len - 1);
        end
        got++;
      end
      if (DONE) begin
        done_k = k;
        @(posedge CLK); #1;
        break;
      end
      @(posedge CLK); #1;
    end
    DATA_READY = 1'b1;
    chk("done_seen", done_k >= 0, 1);
    if (exp_done >= 0) chk("done_cycle", done_k, exp_done);
    chk("words_issued", issued, len);
    chk("words_moved", got, len);
    chk("first_valid", first, exp_first);
    @(negedge CLK);
    chk("done_pulse", DONE, 0);
    chk("idle_ready", REQ_READY, 1);
    chk("idle_valid", DATA_VALID, 0);
    @(posedge CLK); #1;
  endtask

  typedef struct {
    int addr;
    int len;
    int mode;
    int exp_first;
    int exp_done;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{5,   4, 0,  3,  7};
    vecs[1] = '{510, 4, 0,  3,  7};
    vecs[2] = '{20,  8, 1,  3, -1};
    vecs[3] = '{33,  0, 0, -1,  1};
    vecs[4] = '{511, 1, 0,  3,  4};
    vecs[5] = '{200, 6, 1,  3, -1};

    for (int i = 0; i < D; i++) mem[i] = {$urandom, $urandom};

    @(negedge CLK);
    chk_reset_outs("por");
    @(posedge CLK); #1;
    RSTN = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i])
      run_burst(vecs[i].addr, vecs[i].len, vecs[i].mode,
                vecs[i].exp_first, vecs[i].exp_done);

    for (int i = 0; i < 12; i++) begin
      int a;
      int l;
      a = int'($urandom_range(0, D - 1));
      l = int'($urandom_range(0, 12));
      run_burst(a, l, 2, (l > 0) ? 3 : -1, (l > 0) ? -1 : 1);
    end

    // ABORT while the third word of a 16-word burst is presented.
    REQ_ADDR = AW'(100);
    REQ_LEN = LW'(16);
    REQ_VALID = 1'b1;
    DATA_READY = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    ABORT = 1'b1;
    @(negedge CLK);
    chk("abort_word3", DATA_OUT, mem[102]);
    chk("abort_req_ready", REQ_READY, 0);
    chk("abort_rd_enb", RAM_RD_ENB, 0);
    chk("abort_out_rst", RAM_OUT_RST, 1);
    @(posedge CLK); #1;
    ABORT = 1'b0;
    @(negedge CLK);
    chk("post_abort_valid", DATA_VALID, 0);
    chk("post_abort_ready", REQ_READY, 1);
    for (int k = 0; k < 5; k++) begin
      chk("post_abort_done", DONE, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    run_burst(300, 2, 0, 3, 5);

    // Reset in the middle of a burst.
    REQ_ADDR = AW'(50);
    REQ_LEN = LW'(8);
    REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    RSTN = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    @(posedge CLK); #1;
    RSTN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("post_rst_done", DONE, 0);
      chk("post_rst_valid", DATA_VALID, 0);
      @(posedge CLK); #1;
    end
    run_burst(5, 4, 0, 3, 7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
